sincronizador_multicanal: RTL and testbench

Parametrised multi-channel input conditioner: each of `CHANNELS` asynchronous inputs (buttons, switches, external strobes) passes through a two-flop synchroniser, an optional debounce filter and a per-channel edge FSM. The FSM emits a one-clock pulse on the selected edge(s). The block sits at the board-input boundary, ahead of any counter or control FSM that must see exactly one event per press.

---
 rtl/sincronizador_pkg.sv | 17 +
 rtl/sincronizador_canal.sv | 108 ++++++++++
 rtl/sincronizador_multicanal.sv | 30 +++
 tb/tb_sincronizador_multicanal.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sincronizador_pkg.sv
// Shared types for the multi-channel input conditioner: edge FSM encoding and
// the global edge-select mode codes.
package sincronizador_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b11,
    S_FALL = 2'b10
  } state_e;

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

endpackage

// File: rtl/sincronizador_canal.sv
// One input channel: two-flop synchroniser, optional debounce filter
// (SINCRONIZADOR_DEBOUNCE_EN) and a 4-state edge FSM with mode-driven decode.
module sincronizador_canal
  import sincronizador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       in_raw,
  input  logic [1:0] mode,
  output logic       out,
  output logic       level
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic   s1_q, s1_d;
  logic   s2_q, s2_d;
  state_e state_q, state_d;

  // Synchroniser stage
  always_comb begin
    s1_d = in_raw;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef SINCRONIZADOR_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Debounce stage: any return of s2 to the held level restarts the count
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  assign level = s2_q;
`endif

  // Edge FSM stage
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_LOW;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOW:   state_d = level ? S_RISE : S_LOW;
      S_RISE:  state_d = level ? S_HIGH : S_FALL;
      S_HIGH:  state_d = level ? S_HIGH : S_FALL;
      S_FALL:  state_d = level ? S_RISE : S_LOW;
      default: state_d = S_LOW;
    endcase
  end

  // Mode acts on the decode only, so switching it never disturbs the FSM
  always_comb begin
    out = 1'b0;
    case (mode)
      MODE_RISE:  out = (state_q == S_RISE);
      MODE_FALL:  out = (state_q == S_FALL);
      MODE_BOTH:  out = (state_q == S_RISE) || (state_q == S_FALL);
      MODE_LEVEL: out = level;
      default:    out = 1'b0;
    endcase
  end

endmodule

// File: rtl/sincronizador_multicanal.sv
// Multi-channel input conditioner: CHANNELS independent sincronizador_canal
// instances sharing clock, reset and mode. Debounce via SINCRONIZADOR_DEBOUNCE_EN.
module sincronizador_multicanal
  import sincronizador_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [CHANNELS-1:0] in,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] level
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_canal
    sincronizador_canal #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_canal (
      .clk    (clk),
      .clr    (clr),
      .in_raw (in[i]),
      .mode   (mode),
      .out    (out[i]),
      .level  (level[i])
    );
  end

endmodule

// File: tb/tb_sincronizador_multicanal.sv
// Scoreboard bench for sincronizador_multicanal; the reference model follows
// the SINCRONIZADOR_DEBOUNCE_EN setting used to build the design.
module tb_sincronizador_multicanal;
  import sincronizador_pkg::*;

  localparam int CH = 4;
  localparam int D  = 4;
`ifdef SINCRONIZADOR_DEBOUNCE_EN
  localparam int LAT        = 2 + D;
  localparam int EXP_GLITCH = 0;
  localparam int EXP_TOGGLE = 0;
  localparam int EXP_TGAP   = 0;
  localparam int EXP_CLRP   = 1;
`else
  localparam int LAT        = 2;
  localparam int EXP_GLITCH = 1;
  localparam int EXP_TOGGLE = 2;
  localparam int EXP_TGAP   = 1;
  localparam int EXP_CLRP   = 2;
`endif

  typedef struct packed {
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } exp_t;

  logic          clk = 1'b0;
  logic          clr;
  logic [CH-1:0] in_r;
  logic [1:0]    mode;
  logic [CH-1:0] out;
  logic [CH-1:0] level;

  always #5 clk = ~clk;

  sincronizador_multicanal #(
    .CHANNELS(CH),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .in    (in_r),
    .mode  (mode),
    .out   (out),
    .level (level)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   c0;
  int   pulses     [CH];
  int   first_pulse[CH];
  int   last_pulse [CH];
  exp_t exp_q[$];

  logic          m_s1 [CH];
  logic          m_s2 [CH];
  logic          m_lvl[CH];
  logic [D-1:0]  m_hist[CH];
  logic          m_d1 [CH];
  logic          m_d2 [CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic cur_level(input int ch);
`ifdef SINCRONIZADOR_DEBOUNCE_EN
    return m_lvl[ch];
`else
    return m_s2[ch];
`endif
  endfunction

  // Edge behaviour: state reflects the last two sampled levels
  task automatic model_step();
    for (int ch = 0; ch < CH; ch++) begin
      if (clr) begin
        m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_lvl[ch] = 1'b0;
        m_hist[ch] = '0; m_d1[ch] = 1'b0; m_d2[ch] = 1'b0;
      end else begin
        m_d2[ch] = m_d1[ch];
        m_d1[ch] = cur_level(ch);
        m_hist[ch] = (m_hist[ch] << 1) | D'(m_s2[ch]);
        if (m_lvl[ch] ? (m_hist[ch] == '0) : (m_hist[ch] == '1))
          m_lvl[ch] = ~m_lvl[ch];
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = in_r[ch];
      end
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    for (int ch = 0; ch < CH; ch++) begin
      e.lvl[ch]  = cur_level(ch);
      e.rise[ch] = m_d1[ch] & ~m_d2[ch];
      e.fall[ch] = ~m_d1[ch] & m_d2[ch];
    end
    return e;
  endfunction

  task automatic tick();
    exp_t          e;
    logic [CH-1:0] eo;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_exp());
    @(negedge clk);
    cyc++;
    e = exp_q.pop_front();
    case (mode)
      MODE_RISE: eo = e.rise;
      MODE_FALL: eo = e.fall;
      MODE_BOTH: eo = e.rise | e.fall;
      default:   eo = e.lvl;
    endcase
    check_eq("out", 32'(out), 32'(eo));
    check_eq("level", 32'(level), 32'(e.lvl));
    for (int ch = 0; ch < CH; ch++) begin
      if (mode != MODE_LEVEL && out[ch] === 1'b1) begin
        pulses[ch]++;
        if (first_pulse[ch] < 0) first_pulse[ch] = cyc;
        last_pulse[ch] = cyc;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_pulses();
    for (int ch = 0; ch < CH; ch++) begin
      pulses[ch] = 0; first_pulse[ch] = -1; last_pulse[ch] = -1;
    end
  endtask

  initial begin
    clr  = 1'b1;
    in_r = '0;
    mode = MODE_RISE;
    clear_pulses();
    ticks(3);
    check_eq("reset_out", 32'(out), 32'd0);
    check_eq("reset_level", 32'(level), 32'd0);
    clr = 1'b0;
    ticks(2);

    // Single press on ch0, rising mode
    clear_pulses();
    c0 = cyc;
    in_r[0] = 1'b1;
    ticks(14);
    check_eq("t1_pulses", 32'(pulses[0]), 32'd1);
    check_eq("t1_latency", 32'(first_pulse[0] - c0), 32'(LAT + 1));
    check_eq("t1_others", 32'(pulses[1] + pulses[2] + pulses[3]), 32'd0);
    in_r[0] = 1'b0;
    ticks(12);

    // Two-cycle glitch on ch1
    clear_pulses();
    in_r[1] = 1'b1;
    ticks(2);
    in_r[1] = 1'b0;
    ticks(12);
    check_eq("t2_glitch", 32'(pulses[1]), 32'(EXP_GLITCH));

    // Press held 20 cycles on ch2, both edges
    clear_pulses();
    mode = MODE_BOTH;
    in_r[2] = 1'b1;
    ticks(20);
    in_r[2] = 1'b0;
    ticks(14);
    check_eq("t3_pulses", 32'(pulses[2]), 32'd2);
    check_eq("t3_gap", 32'(last_pulse[2] - first_pulse[2]), 32'd20);

    // One-cycle toggle on ch3, both edges
    clear_pulses();
    in_r[3] = 1'b1;
    tick();
    in_r[3] = 1'b0;
    ticks(12);
    check_eq("t4_pulses", 32'(pulses[3]), 32'(EXP_TOGGLE));
    check_eq("t4_gap", 32'(last_pulse[3] - first_pulse[3]), 32'(EXP_TGAP));

    // Reset while ch0 debounce count is at 2
    clear_pulses();
    mode = MODE_RISE;
    in_r[0] = 1'b1;
    ticks(4);
    clr = 1'b1;
    tick();
    check_eq("t5_clr_out", 32'(out), 32'd0);
    check_eq("t5_clr_level", 32'(level), 32'd0);
    clr = 1'b0;
    c0 = cyc;
    ticks(14);
    check_eq("t5_pulses", 32'(pulses[0]), 32'(EXP_CLRP));
    check_eq("t5_latency", 32'(last_pulse[0] - c0), 32'(LAT + 1));

    // Level pass-through, then back to rising while high
    clear_pulses();
    mode = MODE_LEVEL;
    in_r = '1;
    ticks(12);
    check_eq("t6_level_all", 32'(level), 32'hf);
    check_eq("t6_out_eq_level", 32'(out), 32'(level));
    mode = MODE_RISE;
    ticks(6);
    check_eq("t6_no_pulse", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 32'd0);
    in_r = '0;
    ticks(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
